// File: rtl/division_unit_if.sv
// Handshake and operand/result bundle between the multdiv control and the sequential divider.
interface division_unit_if #(parameter int WIDTH = 32);
    logic             ctrl_DIV;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Out;
    logic [WIDTH-1:0] Remainder;
    logic             exception;
    logic             ready;

    modport master (
        output ctrl_DIV, Dividend, Divisor,
        input  Out, Remainder, exception, ready
    );

    modport slave (
        input  ctrl_DIV, Dividend, Divisor,
        output Out, Remainder, exception, ready
    );
endinterface

// File: rtl/division_unit.sv
// Sequential signed divider, one non-restoring step per cycle on operand magnitudes.
// Optional macro DIV_EARLY_OUT_EN: trivial divisors/dividends skip the iteration phase.
//
// state | meaning
// IDLE  | waiting for ctrl_DIV, results held
// RUN   | WIDTH non-restoring shift/add-subtract steps
// FIX   | remainder restore, sign correction, exception decision
// DONE  | publish results and pulse ready
module division_unit #(
    parameter int WIDTH = 32
) (
    input logic           clock,
    input logic           reset_n,
    division_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH:0]   d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [CW-1:0]    counter;
    logic             neg_dvd;
    logic             neg_dvs;
    logic             dvs_zero;
    logic             ovf;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;
    logic             exc_res;

    logic [WIDTH-1:0] mag_dvd;
    logic [WIDTH-1:0] mag_dvs;
    logic             in_dvs_zero;
    logic             in_ovf;
    logic             early;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   a_next;
    logic [WIDTH:0]   a_fix;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Magnitude of the most negative value wraps to itself, which is its correct unsigned magnitude.
    assign mag_dvd     = bus.Dividend[WIDTH-1] ? -bus.Dividend : bus.Dividend;
    assign mag_dvs     = bus.Divisor[WIDTH-1]  ? -bus.Divisor  : bus.Divisor;
    assign in_dvs_zero = (bus.Divisor == '0);
    assign in_ovf      = (bus.Dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.Divisor == '1);

`ifdef DIV_EARLY_OUT_EN
    assign early = in_dvs_zero || (bus.Divisor == WIDTH'(1)) || (bus.Divisor == '1)
                   || (bus.Dividend == '0);
`else
    assign early = 1'b0;
`endif

    assign shifted = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign a_next  = a_reg[WIDTH] ? (shifted + d_reg) : (shifted - d_reg);
    assign a_fix   = a_reg[WIDTH] ? (a_reg + d_reg) : a_reg;
    assign q_fix   = (neg_dvd ^ neg_dvs) ? -q_reg : q_reg;
    assign r_fix   = neg_dvd ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            a_reg         <= '0;
            d_reg         <= '0;
            q_reg         <= '0;
            counter       <= '0;
            neg_dvd       <= 1'b0;
            neg_dvs       <= 1'b0;
            dvs_zero      <= 1'b0;
            ovf           <= 1'b0;
            q_res         <= '0;
            r_res         <= '0;
            exc_res       <= 1'b0;
            bus.Out       <= '0;
            bus.Remainder <= '0;
            bus.exception <= 1'b0;
            bus.ready     <= 1'b0;
        end else if (bus.ctrl_DIV) begin
            neg_dvd   <= bus.Dividend[WIDTH-1];
            neg_dvs   <= bus.Divisor[WIDTH-1];
            dvs_zero  <= in_dvs_zero;
            ovf       <= in_ovf;
            d_reg     <= {1'b0, mag_dvs};
            counter   <= '0;
            bus.ready <= 1'b0;
            if (early) begin
                // With a zero divisor the dividend magnitude parks in A so FIX rebuilds Remainder=Dividend.
                q_reg <= in_dvs_zero ? '0 : mag_dvd;
                a_reg <= in_dvs_zero ? {1'b0, mag_dvd} : '0;
                state <= FIX;
            end else begin
                q_reg <= mag_dvd;
                a_reg <= '0;
                state <= RUN;
            end
        end else begin
            case (state)
                IDLE: begin
                    bus.ready <= 1'b0;
                end
                RUN: begin
                    a_reg   <= a_next;
                    q_reg   <= {q_reg[WIDTH-2:0], ~a_next[WIDTH]};
                    counter <= counter + 1'b1;
                    if (counter == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    a_reg   <= a_fix;
                    q_res   <= dvs_zero ? '0 : q_fix;
                    r_res   <= r_fix;
                    exc_res <= dvs_zero || ovf;
                    state   <= DONE;
                end
                DONE: begin
                    bus.Out       <= q_res;
                    bus.Remainder <= r_res;
                    bus.exception <= exc_res;
                    bus.ready     <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_division_unit.sv
// Directed bench for division_unit: vector table plus abort/reset sequences.
module tb_division_unit;
    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    division_unit_if #(.WIDTH(32)) bus ();

    division_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == 32'd0 || b == 32'd1 || b == 32'hFFFF_FFFF || a == 32'd0) return 2;
`endif
        return 34;
    endfunction

    // Pulse ctrl_DIV for one edge and count edges until ready (bounded).
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clock);
        bus.ctrl_DIV = 1'b1;
        bus.Dividend = a;
        bus.Divisor  = b;
        @(posedge clock);
        #1;
        bus.ctrl_DIV = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clock);
            #1;
            if (bus.ready) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic watch_no_ready(input int cycles, output logic seen);
        seen = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clock);
            #1;
            if (bus.ready) seen = 1'b1;
        end
    endtask

    initial begin
        int   lat;
        logic seen;
        checks   = 0;
        failures = 0;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{-32'sd100,      32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
        vecs[2]  = '{32'd100,        -32'sd7,        32'hFFFF_FFF2,  32'd2,          1'b0};
        vecs[3]  = '{-32'sd100,      -32'sd7,        32'd14,         32'hFFFF_FFFE,  1'b0};
        vecs[4]  = '{32'd5,          32'd0,          32'd0,          32'd5,          1'b1};
        vecs[5]  = '{-32'sd5,        32'd0,          32'd0,          32'hFFFF_FFFB,  1'b1};
        vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b1};
        vecs[7]  = '{32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0};
        vecs[8]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[9]  = '{32'd7,          32'd1,          32'd7,          32'd0,          1'b0};
        vecs[10] = '{32'd7,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  32'd0,          1'b0};
        vecs[11] = '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  1'b0};
        vecs[12] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0};
        vecs[13] = '{32'd3,          32'd5,          32'd0,          32'd3,          1'b0};
        vecs[14] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0};
        vecs[15] = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};

        reset_n      = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.Dividend = '0;
        bus.Divisor  = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset out", bus.Out, 32'd0);
        check("reset rem", bus.Remainder, 32'd0);
        check("reset exc", {31'd0, bus.exception}, 32'd0);
        check("reset ready", {31'd0, bus.ready}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_div(vecs[i].dvd, vecs[i].dvs, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat(vecs[i].dvd, vecs[i].dvs)));
            check($sformatf("vec%0d out", i), bus.Out, vecs[i].q);
            check($sformatf("vec%0d rem", i), bus.Remainder, vecs[i].r);
            check($sformatf("vec%0d exc", i), {31'd0, bus.exception}, {31'd0, vecs[i].exc});
            @(posedge clock);
            #1;
            check($sformatf("vec%0d ready drop", i), {31'd0, bus.ready}, 32'd0);
            check($sformatf("vec%0d out hold", i), bus.Out, vecs[i].q);
        end

        // Restart mid-operation: only the second operation completes.
        @(negedge clock);
        bus.ctrl_DIV = 1'b1;
        bus.Dividend = 32'd1000;
        bus.Divisor  = 32'd3;
        @(posedge clock);
        #1;
        bus.ctrl_DIV = 1'b0;
        watch_no_ready(9, seen);
        check("abort early ready", {31'd0, seen}, 32'd0);
        do_div(32'd9, 32'd4, lat);
        check("abort latency", 32'(lat), 32'd34);
        check("abort out", bus.Out, 32'd2);
        check("abort rem", bus.Remainder, 32'd1);
        watch_no_ready(40, seen);
        check("abort single ready", {31'd0, seen}, 32'd0);

        // Reset mid-operation clears outputs and suppresses ready.
        @(negedge clock);
        bus.ctrl_DIV = 1'b1;
        bus.Dividend = 32'd77;
        bus.Divisor  = 32'd5;
        @(posedge clock);
        #1;
        bus.ctrl_DIV = 1'b0;
        watch_no_ready(19, seen);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("midreset out", bus.Out, 32'd0);
        check("midreset rem", bus.Remainder, 32'd0);
        check("midreset exc", {31'd0, bus.exception}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        watch_no_ready(40, seen);
        check("midreset no ready", {31'd0, seen}, 32'd0);
        do_div(32'd77, 32'd5, lat);
        check("after reset latency", 32'(lat), 32'd34);
        check("after reset out", bus.Out, 32'd15);
        check("after reset rem", bus.Remainder, 32'd2);

        // Reset and start on the same edge: reset wins.
        @(negedge clock);
        reset_n      = 1'b0;
        bus.ctrl_DIV = 1'b1;
        bus.Dividend = 32'd100;
        bus.Divisor  = 32'd7;
        @(posedge clock);
        #1;
        bus.ctrl_DIV = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        watch_no_ready(40, seen);
        check("reset+start no ready", {31'd0, seen}, 32'd0);
        check("reset+start out", bus.Out, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
